// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_pkg : shared defaults and types for the regfile write-back stage        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package wb_pkg;

  localparam int WB_NREG  = 32;
  localparam int WB_XLEN  = 32;
  localparam int WB_CNT_W = 2;
  localparam int WB_IDX_W = $clog2(WB_NREG);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    logic [WB_IDX_W-1:0] rd;
    logic [WB_XLEN-1:0]  data;
  } wb_req_t;

  // Round-robin: on a conflict the producer that did not win last time goes next.
  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_scoreboard : per-register outstanding-write counters, RAW lookups,      |
// |                 saturation check and sticky underflow flag                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NREG  = WB_NREG,
  parameter int CNT_W = WB_CNT_W,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_mark,
  input  logic [IDX_W-1:0] i_mark_rd,
  input  logic             i_retire,
  input  logic [IDX_W-1:0] i_retire_rd,
  input  logic [IDX_W-1:0] i_chk_rs1,
  input  logic [IDX_W-1:0] i_chk_rs2,
  output logic             o_issue_ok,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy,
  output logic             o_err_underflow
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_cnt     [NREG];
  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;
  logic             w_mark_en;
  logic             w_uf;
  logic             r_err;

  // x0 is never marked, so its counter stays 0 and it always reads not-busy.
  assign o_issue_ok = (i_mark_rd == '0) || (r_cnt[i_mark_rd] != c_cnt_max);
  assign w_mark_en  = i_mark && (i_mark_rd != '0) && o_issue_ok;
  assign o_rs1_busy = (r_cnt[i_chk_rs1] != '0);
  assign o_rs2_busy = (r_cnt[i_chk_rs2] != '0);
  assign o_err_underflow = r_err;

  for (genvar g = 0; g < NREG; g++) begin : g_sel
    assign w_inc[g] = w_mark_en && (i_mark_rd == IDX_W'(g));
    assign w_dec[g] = i_retire && (i_retire_rd == IDX_W'(g));
  end

  always_comb begin
    w_uf = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc[i] && !w_dec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
      end
      if (w_dec[i] && (r_cnt[i] == '0)) begin
        w_uf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      if (w_uf) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_writeback : ALU/LSU round-robin write-back arbiter with a one-     |
// |                     cycle register-file write port and RAW scoreboard      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int NREG  = WB_NREG,
  parameter int XLEN  = WB_XLEN,
  parameter int CNT_W = WB_CNT_W,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             issue_mark,
  input  logic [IDX_W-1:0] issue_rd,
  output logic             issue_ok,
  input  logic [IDX_W-1:0] chk_rs1,
  input  logic [IDX_W-1:0] chk_rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             wen,
  output logic [IDX_W-1:0] rd,
  output logic [XLEN-1:0]  wdata,
  output logic             err_underflow
);

  src_e             r_last_grant;
  src_e             w_winner;
  logic             w_conflict;
  logic             w_alu_gnt;
  logic             w_lsu_gnt;
  logic             w_xfer;
  logic             w_retire;
  wb_req_t          w_sel;
  logic             r_wen;
  logic [IDX_W-1:0] r_rd;
  logic [XLEN-1:0]  r_wdata;

  assign w_conflict = alu_valid && lsu_valid;
  assign w_winner   = other_src(r_last_grant);

  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (!hold) begin
      if (w_conflict) begin
        w_alu_gnt = (w_winner == SRC_ALU);
        w_lsu_gnt = (w_winner == SRC_LSU);
      end else begin
        w_alu_gnt = alu_valid;
        w_lsu_gnt = lsu_valid;
      end
    end
  end

  always_comb begin
    w_sel.rd   = alu_rd;
    w_sel.data = alu_data;
    if (w_lsu_gnt) begin
      w_sel.rd   = lsu_rd;
      w_sel.data = lsu_data;
    end
  end

  assign alu_ready = w_alu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign w_xfer    = w_alu_gnt || w_lsu_gnt;
  // Results aimed at x0 are consumed but never written nor retired.
  assign w_retire  = w_xfer && (w_sel.rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= SRC_ALU;
      r_wen        <= 1'b0;
      r_rd         <= '0;
      r_wdata      <= '0;
    end else begin
      r_wen <= w_retire;
      if (w_retire) begin
        r_rd    <= w_sel.rd;
        r_wdata <= w_sel.data;
      end
      if (!hold && w_conflict) begin
        r_last_grant <= w_winner;
      end
    end
  end

  assign wen   = r_wen;
  assign rd    = r_rd;
  assign wdata = r_wdata;

  wb_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .i_mark          (issue_mark),
    .i_mark_rd       (issue_rd),
    .i_retire        (w_retire),
    .i_retire_rd     (w_sel.rd),
    .i_chk_rs1       (chk_rs1),
    .i_chk_rs2       (chk_rs2),
    .o_issue_ok      (issue_ok),
    .o_rs1_busy      (rs1_busy),
    .o_rs2_busy      (rs2_busy),
    .o_err_underflow (err_underflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_writeback : directed and random checks against a counter model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_regfile_writeback;

  localparam int SAT = 3;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_mark;
  logic [4:0]  issue_rd;
  logic        issue_ok;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic        err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_cnt [32];
  bit          m_last_lsu;
  bit          m_wen;
  bit          m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;

  regfile_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .issue_mark    (issue_mark),
    .issue_rd      (issue_rd),
    .issue_ok      (issue_ok),
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .wen           (wen),
    .rd            (rd),
    .wdata         (wdata),
    .err_underflow (err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_last_lsu = 1'b0;
    m_wen      = 1'b0;
    m_err      = 1'b0;
    m_rd       = '0;
    m_wdata    = '0;
  endtask

  function automatic void pred_grant(output bit ag, output bit lg);
    ag = 1'b0;
    lg = 1'b0;
    if (!hold) begin
      if (alu_valid && lsu_valid) begin
        lg = !m_last_lsu;
        ag = m_last_lsu;
      end else begin
        ag = alu_valid;
        lg = lsu_valid;
      end
    end
  endfunction

  task automatic set_idle();
    hold = 0; alu_valid = 0; lsu_valid = 0; issue_mark = 0;
    alu_rd = 0; lsu_rd = 0; alu_data = 0; lsu_data = 0;
    issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
  endtask

  // One clock cycle: check everything against the model at the falling edge,
  // advance the model, and return 1 time unit after the rising edge.
  task automatic step();
    bit          ag, lg, ok, hit;
    logic [4:0]  rrd;
    logic [31:0] rdat;
    @(negedge clk);
    pred_grant(ag, lg);
    ok = (issue_rd == 0) || (m_cnt[issue_rd] < SAT);
    check_eq("alu_ready", alu_ready, ag);
    check_eq("lsu_ready", lsu_ready, lg);
    check_eq("issue_ok", issue_ok, ok);
    check_eq("rs1_busy", rs1_busy, m_cnt[chk_rs1] != 0);
    check_eq("rs2_busy", rs2_busy, m_cnt[chk_rs2] != 0);
    check_eq("wen", wen, m_wen);
    check_eq("rd", rd, m_rd);
    check_eq("wdata", wdata, m_wdata);
    check_eq("err_underflow", err_underflow, m_err);
    if (!hold && alu_valid && lsu_valid) m_last_lsu = lg;
    rrd  = 0;
    rdat = 0;
    if (ag || lg) begin
      rrd  = ag ? alu_rd : lsu_rd;
      rdat = ag ? alu_data : lsu_data;
    end
    m_wen = (rrd != 0);
    if (rrd != 0) begin
      m_rd    = rrd;
      m_wdata = rdat;
    end
    hit = issue_mark && (issue_rd != 0) && ok;
    if (rrd != 0 && m_cnt[rrd] == 0) m_err = 1'b1;
    if (!(hit && rrd == issue_rd)) begin
      if (rrd != 0 && m_cnt[rrd] > 0) m_cnt[rrd]--;
      if (hit) m_cnt[issue_rd]++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         ag, lg;
    logic [4:0] rrd;
    logic [4:0] exp_seq [4];
    exp_seq[0] = 5'd2; exp_seq[1] = 5'd1; exp_seq[2] = 5'd2; exp_seq[3] = 5'd1;

    set_idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wen", wen, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_wdata", wdata, 0);
    check_eq("rst_err", err_underflow, 0);
    rst = 1'b1;

    // Single ALU result, latency 1, one-cycle wen
    issue_mark = 1; issue_rd = 5; step();
    set_idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 check_eq("t1_alu_ready", alu_ready, 1);
    step();
    set_idle();
    check_eq("t1_wen", wen, 1);
    check_eq("t1_rd", rd, 5);
    check_eq("t1_wdata", wdata, 32'hDEADBEEF);
    step();
    check_eq("t1_wen_drop", wen, 0);

    // Round-robin conflict: LSU first after reset
    for (int i = 0; i < 4; i++) begin
      set_idle(); issue_mark = 1; issue_rd = (i < 2) ? 5'd1 : 5'd2; step();
    end
    set_idle();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1111_0001;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h2222_0002;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t2_wen", wen, 1);
      check_eq("t2_rd", rd, exp_seq[i]);
    end
    set_idle(); step();

    // Saturation at 3, ignored fourth mark, retires drain rs1_busy
    issue_mark = 1; issue_rd = 7; chk_rs1 = 7;
    repeat (3) step();
    check_eq("t3_issue_ok_sat", issue_ok, 0);
    step();
    issue_mark = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_0777;
    step(); check_eq("t3_busy_a", rs1_busy, 1);
    step(); check_eq("t3_busy_b", rs1_busy, 1);
    step(); check_eq("t3_busy_c", rs1_busy, 0);

    // Same-cycle mark and retire on the same register
    set_idle(); issue_mark = 1; issue_rd = 9; chk_rs2 = 9; step();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9999_9999;
    step();
    check_eq("t4_rs2_busy", rs2_busy, 1);

    // x0 destination and underflow
    set_idle(); chk_rs2 = 9; alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD0_0000;
    step();
    check_eq("t5_wen_x0", wen, 0);
    check_eq("t5_rs2_kept", rs2_busy, 1);
    check_eq("t5_err_clear", err_underflow, 0);
    set_idle(); chk_rs2 = 9; lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h4444_4444;
    step();
    check_eq("t5_err_set", err_underflow, 1);
    set_idle(); chk_rs2 = 9; step();
    check_eq("t5_err_sticky", err_underflow, 1);

    // Hold, then asynchronous reset mid-stream
    set_idle(); chk_rs2 = 9; hold = 1; alu_valid = 1; lsu_valid = 1; alu_rd = 3; lsu_rd = 6;
    #1 check_eq("t6_hold_alu", alu_ready, 0);
    check_eq("t6_hold_lsu", lsu_ready, 0);
    step();
    check_eq("t6_hold_wen", wen, 0);
    set_idle(); chk_rs2 = 9; alu_valid = 1; alu_rd = 6; alu_data = 32'h6666_6666;
    step();
    check_eq("t6_pre_rst_wen", wen, 1);
    set_idle(); chk_rs2 = 9;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_wen", wen, 0);
    check_eq("t6_rst_err", err_underflow, 0);
    check_eq("t6_rst_busy", rs2_busy, 0);
    model_reset();
    #1 rst = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      hold       = ($urandom_range(0, 9) == 0);
      alu_valid  = $urandom_range(0, 1);
      alu_rd     = $urandom_range(0, 7);
      alu_data   = $urandom;
      lsu_valid  = $urandom_range(0, 1);
      lsu_rd     = $urandom_range(0, 7);
      lsu_data   = $urandom;
      issue_mark = ($urandom_range(0, 9) < 6);
      issue_rd   = $urandom_range(0, 7);
      chk_rs1    = $urandom_range(0, 7);
      chk_rs2    = $urandom_range(0, 7);
      pred_grant(ag, lg);
      rrd = ag ? alu_rd : (lg ? lsu_rd : 5'd0);
      if (issue_mark && rrd != 0 && rrd == issue_rd && m_cnt[rrd] == 0) issue_mark = 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back stage that drives the write port of the NPC integer register file (wen/rd/wdata) on behalf of two result producers: ALU and LSU.
- Arbitrates the two producers with a valid/ready handshake and registers the winning result for one cycle onto the register-file write port.
- Keeps a per-register outstanding-write scoreboard so the issue stage can detect RAW hazards on rs1/rs2 and can stall issue when a destination's counter is saturated.

Parameters:
- NREG, 32, number of architectural registers; index width is clog2(NREG).
- XLEN, 32, data width.
- CNT_W, 2, width of each per-register outstanding-write counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- hold  input  1  freeze; while 1, no producer is granted.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  LSU result valid.
- lsu_ready  output  1  LSU result accepted this cycle.
- lsu_rd  input  5  LSU destination register.
- lsu_data  input  XLEN  LSU load data.
- issue_mark  input  1  issue stage dispatched an instruction writing issue_rd.
- issue_rd  input  5  destination of the dispatched instruction.
- issue_ok  output  1  counter[issue_rd] is not saturated; marking is permitted.
- chk_rs1  input  5  source 1 lookup index.
- chk_rs2  input  5  source 2 lookup index.
- rs1_busy  output  1  counter[chk_rs1] != 0.
- rs2_busy  output  1  counter[chk_rs2] != 0.
- wen  output  1  register-file write enable.
- rd  output  5  register-file write index.
- wdata  output  XLEN  register-file write data.
- err_underflow  output  1  sticky flag: a retire hit a zero counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - wen=0, rd=0, wdata=0.
  - All counters 0; err_underflow=0.
  - last_grant=ALU.
  - In-flight results are discarded. wen falls immediately, without waiting for a clock edge.
- Arbitration (combinational):
  - hold=1: both readies 0.
  - Exactly one valid: that producer is granted.
  - Both valid: round-robin; the producer not in last_grant wins, so LSU wins the first conflict after reset.
  - last_grant updates only on a conflict grant.
  - ready is asserted only in the granting cycle; a transfer occurs when valid&ready.
- Output register:
  - Transfer in cycle N: wen=1, rd, wdata appear in cycle N+1 for exactly one cycle.
  - No transfer: wen=0 next cycle; rd/wdata hold their last values.
  - Transfer with rd=0: wen=0 next cycle; the data is dropped; the counter is untouched.
  - Throughput: one result per cycle, latency 1.
- Scoreboard:
  - Retire event = transfer with rd!=0, applied to counter[rd] at the transfer edge.
  - issue_mark with issue_rd!=0 and issue_ok=1 increments counter[issue_rd].
  - issue_mark when issue_ok=0 is ignored.
  - Same-cycle mark and retire on the same rd: net 0 change.
  - Retire on counter 0: the counter stays 0 and err_underflow is set. It clears only on reset.
  - Counters saturate at 2^CNT_W-1, where issue_ok=0.
  - issue_ok, rs1_busy and rs2_busy are combinational from the current counters; a same-cycle retire is not reflected until the next cycle.
  - x0 always reads busy=0 and issue_ok=1.
- Reset mid-transfer: a granted result whose edge coincides with rst low is lost. Producers must re-present it after reset.

Decomposition:
- Package wb_pkg holds NREG, XLEN and CNT_W defaults, the src_e enum {SRC_ALU, SRC_LSU} used for last_grant, and the wb_req_t struct {rd, data}.
- One sub-module, wb_scoreboard: the counter array, mark/retire update, lookups and underflow flag.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 in cycle 0; wen=1, rd=5, wdata=0xDEADBEEF in cycle 1; wen=0 in cycle 2.
- Both valid for 4 cycles (alu_rd=1, lsu_rd=2, data held per producer) -> grants LSU, ALU, LSU, ALU; rd sequence 2,1,2,1 with wen=1 on four consecutive cycles.
- issue_mark rd=7 three times -> issue_ok=0; a fourth mark is ignored; then three ALU retires to rd=7 -> rs1_busy (chk_rs1=7) falls only after the third retire.
- Same cycle: issue_mark rd=9 and LSU retire rd=9 with counter=1 -> counter stays 1 and rs2_busy (chk_rs2=9) stays 1.
- ALU transfer with alu_rd=0 -> wen=0 next cycle and the counters are unchanged; LSU retire to rd=4 with counter 0 -> err_underflow=1 and stays set.
- hold=1 with both valid -> both readies 0 and wen=0; assert rst low mid-stream -> wen, counters and err_underflow clear before the next edge.
